// File: rtl/tdp_ram36k_port_arbiter.sv
// ---------------------------------------------------------------------------
// tdp_ram36k_port_arbiter
// Arbitrates two requesters onto a single RAM36K port. After reset the RAM is
// optionally zero-filled (one word per cycle). Then one request is granted per
// cycle, either round-robin or with requester 0 having fixed priority. Read
// data comes back one cycle after acceptance and is routed to the requester
// that issued the read.
//
// Parameters
//   ADDR_WIDTH  RAM word-address width
//   INIT_EN     1 = zero-fill after reset, 0 = go straight to arbitration
//   FIXED_PRIO  0 = round-robin, 1 = requester 0 always wins
//
// Ports
//   CLK, RST                       clock, synchronous active-high reset
//   REQn_VALID/WE/ADDR/BE/WDATA/WPARITY   request inputs, n = 0,1
//   REQn_READY                     request accepted this cycle
//   RSPn_VALID/RDATA/RPARITY       read response for requester n
//   INIT_DONE                      high once the fill has finished
//   RAM_WEN/REN/ADDR/BE/WDATA/WPARITY     RAM port command
//   RAM_RDATA/RPARITY              RAM read data, one cycle after REN
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_INIT | zero-fill, one RAM write per cycle, requesters stalled
// ST_RUN  | arbitrate requesters, return read data one cycle later
// ---------------------------------------------------------------------------
module tdp_ram36k_port_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int INIT_EN    = 1,
   parameter int FIXED_PRIO = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ0_VALID,
   input  logic                  REQ0_WE,
   input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
   input  logic [3:0]            REQ0_BE,
   input  logic [31:0]           REQ0_WDATA,
   input  logic [3:0]            REQ0_WPARITY,
   output logic                  REQ0_READY,
   input  logic                  REQ1_VALID,
   input  logic                  REQ1_WE,
   input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
   input  logic [3:0]            REQ1_BE,
   input  logic [31:0]           REQ1_WDATA,
   input  logic [3:0]            REQ1_WPARITY,
   output logic                  REQ1_READY,
   output logic                  RSP0_VALID,
   output logic [31:0]           RSP0_RDATA,
   output logic [3:0]            RSP0_RPARITY,
   output logic                  RSP1_VALID,
   output logic [31:0]           RSP1_RDATA,
   output logic [3:0]            RSP1_RPARITY,
   output logic                  INIT_DONE,
   output logic                  RAM_WEN,
   output logic                  RAM_REN,
   output logic [ADDR_WIDTH-1:0] RAM_ADDR,
   output logic [3:0]            RAM_BE,
   output logic [31:0]           RAM_WDATA,
   output logic [3:0]            RAM_WPARITY,
   input  logic [31:0]           RAM_RDATA,
   input  logic [3:0]            RAM_RPARITY
);

   typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

   localparam logic [ADDR_WIDTH-1:0] FILL_LAST = {ADDR_WIDTH{1'b1}};

   state_t                state;
   logic [ADDR_WIDTH-1:0] fill_cnt;
   logic                  last_grant;
   logic                  rd_pend;
   logic                  rd_owner;
   logic                  gnt0;
   logic                  gnt1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
         fill_cnt   <= '0;
         last_grant <= 1'b1;
         rd_pend    <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         rd_pend <= 1'b0;
         case (state)
            ST_INIT: begin
               fill_cnt <= fill_cnt + 1'b1;
               if (fill_cnt == FILL_LAST) state <= ST_RUN;
            end
            ST_RUN: begin
               if (gnt0 || gnt1) begin
                  last_grant <= gnt1;
                  rd_owner   <= gnt1;
               end
               rd_pend <= (gnt0 && !REQ0_WE) || (gnt1 && !REQ1_WE);
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   // Grants and RAM command are combinational so a request is accepted in
   // the same cycle it is presented. Everything is forced idle while RST is
   // high so nothing reaches the RAM during the reset cycle itself.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == ST_RUN && !RST) begin
         // A tie goes to requester 0 when fixed priority is selected or when
         // requester 1 was the most recent winner.
         gnt0 = REQ0_VALID && (!REQ1_VALID || (FIXED_PRIO != 0) || last_grant);
         gnt1 = REQ1_VALID && !gnt0;
      end
   end

   always_comb begin
      RAM_WEN     = 1'b0;
      RAM_REN     = 1'b0;
      RAM_ADDR    = gnt1 ? REQ1_ADDR    : REQ0_ADDR;
      RAM_BE      = gnt1 ? REQ1_BE      : REQ0_BE;
      RAM_WDATA   = gnt1 ? REQ1_WDATA   : REQ0_WDATA;
      RAM_WPARITY = gnt1 ? REQ1_WPARITY : REQ0_WPARITY;
      if (state == ST_INIT && !RST) begin
         RAM_WEN     = 1'b1;
         RAM_ADDR    = fill_cnt;
         RAM_BE      = 4'hF;
         RAM_WDATA   = 32'h0;
         RAM_WPARITY = 4'h0;
      end else if (gnt1) begin
         RAM_WEN = REQ1_WE;
         RAM_REN = !REQ1_WE;
      end else if (gnt0) begin
         RAM_WEN = REQ0_WE;
         RAM_REN = !REQ0_WE;
      end
   end

   assign REQ0_READY = gnt0;
   assign REQ1_READY = gnt1;
   assign INIT_DONE  = (state == ST_RUN) && !RST;

   // A read pending across a reset edge is dropped; the gate on RST also
   // hides it during the reset cycle itself.
   assign RSP0_VALID   = rd_pend && !rd_owner && !RST;
   assign RSP1_VALID   = rd_pend &&  rd_owner && !RST;
   assign RSP0_RDATA   = RAM_RDATA;
   assign RSP0_RPARITY = RAM_RPARITY;
   assign RSP1_RDATA   = RAM_RDATA;
   assign RSP1_RPARITY = RAM_RPARITY;

endmodule

// File: tb/tb_tdp_ram36k_port_arbiter.sv
module tb_tdp_ram36k_port_arbiter;

   localparam int AW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          REQ0_VALID, REQ0_WE, REQ1_VALID, REQ1_WE;
   logic [AW-1:0] REQ0_ADDR, REQ1_ADDR;
   logic [3:0]    REQ0_BE, REQ1_BE, REQ0_WPARITY, REQ1_WPARITY;
   logic [31:0]   REQ0_WDATA, REQ1_WDATA;

   logic          rr_ready0, rr_ready1, rr_rsp0_valid, rr_rsp1_valid, rr_init_done;
   logic [31:0]   rr_rsp0_rdata, rr_rsp1_rdata, rr_wdata, rr_rdata;
   logic [3:0]    rr_rsp0_rparity, rr_rsp1_rparity, rr_be, rr_wparity, rr_rparity;
   logic          rr_wen, rr_ren;
   logic [AW-1:0] rr_addr;

   logic          fp_ready0, fp_ready1, fp_rsp0_valid, fp_rsp1_valid, fp_init_done;
   logic [31:0]   fp_rsp0_rdata, fp_rsp1_rdata, fp_wdata, fp_rdata;
   logic [3:0]    fp_rsp0_rparity, fp_rsp1_rparity, fp_be, fp_wparity, fp_rparity;
   logic          fp_wen, fp_ren;
   logic [AW-1:0] fp_addr;

   logic [31:0]   rr_mem [16];
   logic [3:0]    rr_pmem[16];
   logic [31:0]   fp_mem [16];
   logic [3:0]    fp_pmem[16];

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   tdp_ram36k_port_arbiter #(.ADDR_WIDTH(AW), .INIT_EN(1), .FIXED_PRIO(0)) dut_rr (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_WE(REQ0_WE), .REQ0_ADDR(REQ0_ADDR), .REQ0_BE(REQ0_BE),
      .REQ0_WDATA(REQ0_WDATA), .REQ0_WPARITY(REQ0_WPARITY), .REQ0_READY(rr_ready0),
      .REQ1_VALID(REQ1_VALID), .REQ1_WE(REQ1_WE), .REQ1_ADDR(REQ1_ADDR), .REQ1_BE(REQ1_BE),
      .REQ1_WDATA(REQ1_WDATA), .REQ1_WPARITY(REQ1_WPARITY), .REQ1_READY(rr_ready1),
      .RSP0_VALID(rr_rsp0_valid), .RSP0_RDATA(rr_rsp0_rdata), .RSP0_RPARITY(rr_rsp0_rparity),
      .RSP1_VALID(rr_rsp1_valid), .RSP1_RDATA(rr_rsp1_rdata), .RSP1_RPARITY(rr_rsp1_rparity),
      .INIT_DONE(rr_init_done), .RAM_WEN(rr_wen), .RAM_REN(rr_ren), .RAM_ADDR(rr_addr),
      .RAM_BE(rr_be), .RAM_WDATA(rr_wdata), .RAM_WPARITY(rr_wparity),
      .RAM_RDATA(rr_rdata), .RAM_RPARITY(rr_rparity));

   tdp_ram36k_port_arbiter #(.ADDR_WIDTH(AW), .INIT_EN(1), .FIXED_PRIO(1)) dut_fp (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_WE(REQ0_WE), .REQ0_ADDR(REQ0_ADDR), .REQ0_BE(REQ0_BE),
      .REQ0_WDATA(REQ0_WDATA), .REQ0_WPARITY(REQ0_WPARITY), .REQ0_READY(fp_ready0),
      .REQ1_VALID(REQ1_VALID), .REQ1_WE(REQ1_WE), .REQ1_ADDR(REQ1_ADDR), .REQ1_BE(REQ1_BE),
      .REQ1_WDATA(REQ1_WDATA), .REQ1_WPARITY(REQ1_WPARITY), .REQ1_READY(fp_ready1),
      .RSP0_VALID(fp_rsp0_valid), .RSP0_RDATA(fp_rsp0_rdata), .RSP0_RPARITY(fp_rsp0_rparity),
      .RSP1_VALID(fp_rsp1_valid), .RSP1_RDATA(fp_rsp1_rdata), .RSP1_RPARITY(fp_rsp1_rparity),
      .INIT_DONE(fp_init_done), .RAM_WEN(fp_wen), .RAM_REN(fp_ren), .RAM_ADDR(fp_addr),
      .RAM_BE(fp_be), .RAM_WDATA(fp_wdata), .RAM_WPARITY(fp_wparity),
      .RAM_RDATA(fp_rdata), .RAM_RPARITY(fp_rparity));

   // Behavioural RAM per DUT: byte-enabled write, one-cycle registered read.
   always @(posedge CLK) begin
      if (rr_wen)
         for (int b = 0; b < 4; b++)
            if (rr_be[b]) begin
               rr_mem[rr_addr][8*b +: 8] <= rr_wdata[8*b +: 8];
               rr_pmem[rr_addr][b]       <= rr_wparity[b];
            end
      if (rr_ren) begin
         rr_rdata   <= rr_mem[rr_addr];
         rr_rparity <= rr_pmem[rr_addr];
      end
   end

   always @(posedge CLK) begin
      if (fp_wen)
         for (int b = 0; b < 4; b++)
            if (fp_be[b]) begin
               fp_mem[fp_addr][8*b +: 8] <= fp_wdata[8*b +: 8];
               fp_pmem[fp_addr][b]       <= fp_wparity[b];
            end
      if (fp_ren) begin
         fp_rdata   <= fp_mem[fp_addr];
         fp_rparity <= fp_pmem[fp_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic req0(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] d, input logic [3:0] p);
      REQ0_VALID = v; REQ0_WE = we; REQ0_ADDR = a; REQ0_BE = be; REQ0_WDATA = d; REQ0_WPARITY = p;
   endtask

   task automatic req1(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] d, input logic [3:0] p);
      REQ1_VALID = v; REQ1_WE = we; REQ1_ADDR = a; REQ1_BE = be; REQ1_WDATA = d; REQ1_WPARITY = p;
   endtask

   initial begin
      // Reset with both requesters asserting: nothing must get through.
      RST = 1'b1;
      req0(1'b1, 1'b0, 4'd2, 4'hF, 32'h0, 4'h0);
      req1(1'b1, 1'b0, 4'd9, 4'hF, 32'h0, 4'h0);
      tick();
      tick();
      @(negedge CLK);
      check("rst_ready0",    {31'b0, rr_ready0},     32'd0);
      check("rst_ready1",    {31'b0, rr_ready1},     32'd0);
      check("rst_wen",       {31'b0, rr_wen},        32'd0);
      check("rst_ren",       {31'b0, rr_ren},        32'd0);
      check("rst_init_done", {31'b0, rr_init_done},  32'd0);
      check("rst_rsp0",      {31'b0, rr_rsp0_valid}, 32'd0);
      tick();
      RST = 1'b0;

      // Zero-fill: 16 writes at addresses 0..15, requesters held off.
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         check("fill_wen",    {31'b0, rr_wen},    32'd1);
         check("fill_addr",   {28'b0, rr_addr},   i);
         check("fill_be",     {28'b0, rr_be},     32'hF);
         check("fill_wdata",  rr_wdata,           32'h0);
         check("fill_ready0", {31'b0, rr_ready0}, 32'd0);
         check("fill_ready1", {31'b0, fp_ready1}, 32'd0);
         check("fill_done",   {31'b0, rr_init_done}, 32'd0);
         tick();
      end
      req0(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      req1(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      @(negedge CLK);
      check("init_done_rr", {31'b0, rr_init_done}, 32'd1);
      check("init_done_fp", {31'b0, fp_init_done}, 32'd1);
      check("idle_wen",     {31'b0, rr_wen},       32'd0);
      check("idle_ren",     {31'b0, rr_ren},       32'd0);

      // Read of a filled location returns zero.
      req0(1'b1, 1'b0, 4'd7, 4'hF, 32'h0, 4'h0);
      @(negedge CLK);
      check("rd7_ready0", {31'b0, rr_ready0}, 32'd1);
      check("rd7_ren",    {31'b0, rr_ren},    32'd1);
      check("rd7_addr",   {28'b0, rr_addr},   32'd7);
      tick();
      req0(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      @(negedge CLK);
      check("rd7_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd1);
      check("rd7_rdata",      rr_rsp0_rdata,           32'h0);
      check("rd7_rparity",    {28'b0, rr_rsp0_rparity}, 32'h0);
      check("rd7_rsp1_valid", {31'b0, rr_rsp1_valid}, 32'd0);
      tick();

      // Write then read the same address on consecutive cycles.
      req0(1'b1, 1'b1, 4'd0, 4'hF, 32'h12345678, 4'b1010);
      @(negedge CLK);
      check("wr0_ready0", {31'b0, rr_ready0}, 32'd1);
      check("wr0_wen",    {31'b0, rr_wen},    32'd1);
      check("wr0_ren",    {31'b0, rr_ren},    32'd0);
      check("wr0_wdata",  rr_wdata,           32'h12345678);
      check("wr0_wpar",   {28'b0, rr_wparity}, 32'hA);
      tick();
      req0(1'b1, 1'b0, 4'd0, 4'hF, 32'h0, 4'h0);
      @(negedge CLK);
      check("wr0_no_rsp", {31'b0, rr_rsp0_valid}, 32'd0);
      check("rd0_ren",    {31'b0, rr_ren},        32'd1);
      tick();
      req0(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      @(negedge CLK);
      check("rd0_rsp0_valid", {31'b0, rr_rsp0_valid},  32'd1);
      check("rd0_rdata",      rr_rsp0_rdata,            32'h12345678);
      check("rd0_rparity",    {28'b0, rr_rsp0_rparity}, 32'hA);
      check("rd0_rsp1_valid", {31'b0, rr_rsp1_valid},  32'd0);
      tick();

      // Partial byte write merges with existing data; read back via req1.
      req0(1'b1, 1'b1, 4'd3, 4'hF, 32'hAABBCCDD, 4'h0);
      tick();
      req0(1'b1, 1'b1, 4'd3, 4'b0011, 32'hFFFFFFFF, 4'h0);
      @(negedge CLK);
      check("be_wr_be", {28'b0, rr_be}, 32'h3);
      tick();
      req0(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      req1(1'b1, 1'b0, 4'd3, 4'hF, 32'h0, 4'h0);
      @(negedge CLK);
      check("be_rd_ready1", {31'b0, rr_ready1}, 32'd1);
      check("be_rd_ready0", {31'b0, rr_ready0}, 32'd0);
      tick();
      req1(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      @(negedge CLK);
      check("be_rsp1_valid", {31'b0, rr_rsp1_valid}, 32'd1);
      check("be_rsp1_rdata", rr_rsp1_rdata,           32'hAABBFFFF);
      check("be_rsp0_valid", {31'b0, rr_rsp0_valid}, 32'd0);
      tick();

      // Both requesters read for 4 cycles: req0 addr 0, req1 addr 3.
      // Last winner was req1, so round-robin starts with req0.
      req0(1'b1, 1'b0, 4'd0, 4'hF, 32'h0, 4'h0);
      req1(1'b1, 1'b0, 4'd3, 4'hF, 32'h0, 4'h0);
      @(negedge CLK);
      check("tie_a_rr_ready0", {31'b0, rr_ready0}, 32'd1);
      check("tie_a_rr_ready1", {31'b0, rr_ready1}, 32'd0);
      check("tie_a_rr_addr",   {28'b0, rr_addr},   32'd0);
      check("tie_a_fp_ready0", {31'b0, fp_ready0}, 32'd1);
      check("tie_a_fp_ready1", {31'b0, fp_ready1}, 32'd0);
      tick();
      @(negedge CLK);
      check("tie_b_rr_ready1", {31'b0, rr_ready1},     32'd1);
      check("tie_b_rr_ready0", {31'b0, rr_ready0},     32'd0);
      check("tie_b_rr_addr",   {28'b0, rr_addr},       32'd3);
      check("tie_b_rr_rsp0",   {31'b0, rr_rsp0_valid}, 32'd1);
      check("tie_b_rr_data0",  rr_rsp0_rdata,          32'h12345678);
      check("tie_b_rr_rsp1",   {31'b0, rr_rsp1_valid}, 32'd0);
      check("tie_b_fp_ready0", {31'b0, fp_ready0},     32'd1);
      check("tie_b_fp_ready1", {31'b0, fp_ready1},     32'd0);
      check("tie_b_fp_rsp0",   {31'b0, fp_rsp0_valid}, 32'd1);
      tick();
      @(negedge CLK);
      check("tie_c_rr_ready0", {31'b0, rr_ready0},     32'd1);
      check("tie_c_rr_rsp1",   {31'b0, rr_rsp1_valid}, 32'd1);
      check("tie_c_rr_rsp0",   {31'b0, rr_rsp0_valid}, 32'd0);
      check("tie_c_rr_data1",  rr_rsp1_rdata,          32'hAABBFFFF);
      check("tie_c_fp_ready1", {31'b0, fp_ready1},     32'd0);
      check("tie_c_fp_rsp1",   {31'b0, fp_rsp1_valid}, 32'd0);
      check("tie_c_fp_data0",  fp_rsp0_rdata,          32'h12345678);
      tick();
      @(negedge CLK);
      check("tie_d_rr_ready1", {31'b0, rr_ready1},     32'd1);
      check("tie_d_rr_rsp0",   {31'b0, rr_rsp0_valid}, 32'd1);
      check("tie_d_rr_data0",  rr_rsp0_rdata,          32'h12345678);
      check("tie_d_fp_ready0", {31'b0, fp_ready0},     32'd1);
      check("tie_d_fp_ready1", {31'b0, fp_ready1},     32'd0);
      tick();
      req0(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      req1(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      @(negedge CLK);
      check("tie_e_rr_rsp1",  {31'b0, rr_rsp1_valid}, 32'd1);
      check("tie_e_rr_rsp0",  {31'b0, rr_rsp0_valid}, 32'd0);
      check("tie_e_rr_data1", rr_rsp1_rdata,          32'hAABBFFFF);
      check("tie_e_fp_rsp0",  {31'b0, fp_rsp0_valid}, 32'd1);
      check("tie_e_fp_rsp1",  {31'b0, fp_rsp1_valid}, 32'd0);
      check("tie_e_rr_ren",   {31'b0, rr_ren},        32'd0);
      tick();

      // Reset in the middle of the fill, at address 5.
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      @(negedge CLK);
      check("mid_fill_addr", {28'b0, rr_addr}, 32'd5);
      check("mid_fill_wen",  {31'b0, rr_wen},  32'd1);
      RST = 1'b1;
      #1;
      check("mid_rst_wen", {31'b0, rr_wen}, 32'd0);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      check("refill_addr", {28'b0, rr_addr}, 32'd0);
      check("refill_wen",  {31'b0, rr_wen},  32'd1);
      for (int i = 0; i < 16; i++) tick();
      @(negedge CLK);
      check("refill_done", {31'b0, rr_init_done}, 32'd1);

      // Reset in the cycle after a read accept drops the response.
      req0(1'b1, 1'b0, 4'd0, 4'hF, 32'h0, 4'h0);
      @(negedge CLK);
      check("pend_ready0", {31'b0, rr_ready0}, 32'd1);
      tick();
      req0(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'h0);
      RST = 1'b1;
      @(negedge CLK);
      check("pend_rst_rsp0",    {31'b0, rr_rsp0_valid}, 32'd0);
      check("pend_rst_fp_rsp0", {31'b0, fp_rsp0_valid}, 32'd0);
      check("pend_rst_done",    {31'b0, rr_init_done},  32'd0);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      check("post_rst_rsp0", {31'b0, rr_rsp0_valid}, 32'd0);
      check("post_rst_rsp1", {31'b0, rr_rsp1_valid}, 32'd0);
      check("post_rst_addr", {28'b0, rr_addr},       32'd0);
      check("post_rst_wen",  {31'b0, rr_wen},        32'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
